// File: rtl/cpu_test_monitor.sv
// cpu_test_monitor: walks a table of (instruction count, expected value, lane)
// checkpoints against the CPU debug outputs, tallies pass/fail/miss results,
// runs a cycle watchdog and records why the run finished.
module cpu_test_monitor #(
    parameter int WORD_SIZE    = 16,
    parameter int NUM_TEST     = 56,
    parameter int NUM_PORTS    = 1,
    parameter int MAX_CYCLES   = 10000,
    parameter int CYC_W        = 16,
    parameter int STOP_ON_FAIL = 1,
    localparam int IDX_W       = $clog2(NUM_TEST),
    localparam int CHAN_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           tbl_we,
    input  logic [IDX_W-1:0]               tbl_addr,
    input  logic [WORD_SIZE-1:0]           tbl_inst,
    input  logic [WORD_SIZE-1:0]           tbl_ans,
    input  logic [CHAN_W-1:0]              tbl_chan,
    input  logic [WORD_SIZE-1:0]           num_inst,
    input  logic [NUM_PORTS*WORD_SIZE-1:0] output_port,
    input  logic                           is_halted,
    output logic                           busy,
    output logic                           done,
    output logic                           all_pass,
    output logic [IDX_W:0]                 pass_count,
    output logic [IDX_W:0]                 fail_count,
    output logic [IDX_W:0]                 miss_count,
    output logic [CYC_W-1:0]               cycle_count,
    output logic [IDX_W-1:0]               fail_idx,
    output logic [WORD_SIZE-1:0]           fail_value,
    output logic [1:0]                     finish_cause
);

    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_HALT    = 2'b01;
    localparam logic [1:0] CAUSE_FAIL    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    state_t state, state_next;

    logic [WORD_SIZE-1:0] inst_mem [NUM_TEST];
    logic [WORD_SIZE-1:0] ans_mem  [NUM_TEST];
    logic [CHAN_W-1:0]    chan_mem [NUM_TEST];

    logic [CNT_W-1:0]     ptr, ptr_next;
    logic [CNT_W-1:0]     pass_next, fail_next, miss_next;
    logic [CYC_W-1:0]     cyc_next, cyc_inc;
    logic [IDX_W-1:0]     fidx_next;
    logic [WORD_SIZE-1:0] fval_next;
    logic [1:0]           cause_next;

    logic [IDX_W-1:0]     ptr_idx;
    logic                 ptr_active;
    logic [WORD_SIZE-1:0] cur_inst, cur_ans, lane_val;
    logic [CHAN_W-1:0]    cur_chan;
    logic                 entry_fail;

    assign ptr_idx    = ptr[IDX_W-1:0];
    assign ptr_active = (ptr < CNT_W'(NUM_TEST));
    assign cur_inst   = inst_mem[ptr_idx];
    assign cur_ans    = ans_mem[ptr_idx];
    assign cur_chan   = chan_mem[ptr_idx];

    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    assign all_pass = done && (pass_count == CNT_W'(NUM_TEST));

    // Table storage survives reset; the CPU program is loaded once and rerun.
    always_ff @(posedge clk) begin
        if (tbl_we && state != S_RUN) begin
            inst_mem[tbl_addr] <= tbl_inst;
            ans_mem[tbl_addr]  <= tbl_ans;
            chan_mem[tbl_addr] <= tbl_chan;
        end
    end

    // Pick the output_port lane named by the current entry; unused lane codes read zero.
    always_comb begin
        lane_val = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (cur_chan == CHAN_W'(k)) begin
                lane_val = output_port[k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Next-state logic: retire at most one entry per RUN cycle, then decide whether the run ends.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        pass_next  = pass_count;
        fail_next  = fail_count;
        miss_next  = miss_count;
        cyc_next   = cycle_count;
        fidx_next  = fail_idx;
        fval_next  = fail_value;
        cause_next = finish_cause;
        entry_fail = 1'b0;
        cyc_inc    = (cycle_count == '1) ? cycle_count : cycle_count + CYC_W'(1);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                    ptr_next   = '0;
                    pass_next  = '0;
                    fail_next  = '0;
                    miss_next  = '0;
                    cyc_next   = '0;
                    fidx_next  = '0;
                    fval_next  = '0;
                    cause_next = CAUSE_NONE;
                end
            end
            S_RUN: begin
                cyc_next = cyc_inc;
                if (ptr_active) begin
                    if (num_inst == cur_inst) begin
                        ptr_next = ptr + CNT_W'(1);
                        if (lane_val == cur_ans) begin
                            pass_next = pass_count + CNT_W'(1);
                        end else begin
                            fail_next  = fail_count + CNT_W'(1);
                            entry_fail = 1'b1;
                            if (fail_count == '0) begin
                                fidx_next = ptr_idx;
                                fval_next = lane_val;
                            end
                        end
                    end else if (num_inst > cur_inst) begin
                        ptr_next  = ptr + CNT_W'(1);
                        miss_next = miss_count + CNT_W'(1);
                    end
                end
                if ((STOP_ON_FAIL != 0) && entry_fail) begin
                    cause_next = CAUSE_FAIL;
                    state_next = S_DONE;
                end else if (is_halted) begin
                    cause_next = CAUSE_HALT;
                    state_next = S_DONE;
                end else if (cyc_inc == CYC_W'(MAX_CYCLES - 1)) begin
                    cause_next = CAUSE_TIMEOUT;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and result registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            ptr          <= '0;
            pass_count   <= '0;
            fail_count   <= '0;
            miss_count   <= '0;
            cycle_count  <= '0;
            fail_idx     <= '0;
            fail_value   <= '0;
            finish_cause <= CAUSE_NONE;
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            pass_count   <= pass_next;
            fail_count   <= fail_next;
            miss_count   <= miss_next;
            cycle_count  <= cyc_next;
            fail_idx     <= fidx_next;
            fail_value   <= fval_next;
            finish_cause <= cause_next;
        end
    end

endmodule

// File: tb/tb_cpu_test_monitor.sv
// tb_cpu_test_monitor: directed and randomized runs of cpu_test_monitor,
// compared cycle by cycle against a checkpoint-walking reference model.
module tb_cpu_test_monitor;

    localparam int NT   = 3;
    localparam int NP   = 2;
    localparam int MAXC = 20;
    localparam int CW   = 16;
    localparam int TLEN = 64;

    logic        clk = 1'b0;
    logic        reset, start, tbl_we, is_halted;
    logic [1:0]  tbl_addr;
    logic [15:0] tbl_inst, tbl_ans, num_inst;
    logic [0:0]  tbl_chan;
    logic [31:0] output_port;
    logic        busy, done, all_pass;
    logic [2:0]  pass_count, fail_count, miss_count;
    logic [15:0] cycle_count, fail_value;
    logic [1:0]  fail_idx, finish_cause;

    int checks = 0;
    int errors = 0;
    string step_name;

    int m_inst [NT];
    int m_ans  [NT];
    int m_chan [NT];

    int tr_inst [TLEN];
    int tr_l0   [TLEN];
    int tr_l1   [TLEN];
    bit tr_halt [TLEN];

    int e_busy [TLEN+1];
    int e_done [TLEN+1];
    int e_pc   [TLEN+1];
    int e_fc   [TLEN+1];
    int e_mc   [TLEN+1];
    int e_cc   [TLEN+1];
    int e_fidx [TLEN+1];
    int e_fval [TLEN+1];
    int e_cause[TLEN+1];

    cpu_test_monitor #(
        .WORD_SIZE(16), .NUM_TEST(NT), .NUM_PORTS(NP),
        .MAX_CYCLES(MAXC), .CYC_W(CW), .STOP_ON_FAIL(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tbl_we(tbl_we),
        .tbl_addr(tbl_addr), .tbl_inst(tbl_inst), .tbl_ans(tbl_ans),
        .tbl_chan(tbl_chan), .num_inst(num_inst), .output_port(output_port),
        .is_halted(is_halted), .busy(busy), .done(done), .all_pass(all_pass),
        .pass_count(pass_count), .fail_count(fail_count), .miss_count(miss_count),
        .cycle_count(cycle_count), .fail_idx(fail_idx), .fail_value(fail_value),
        .finish_cause(finish_cause)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", step_name, tag, obs, exp);
        end
    endtask

    // Reference: walk the checkpoint list in order, one retirement per cycle,
    // and stop on first mismatch, halt, or watchdog expiry.
    task automatic buildModel(input int len);
        int ptr, pc, fc, mc, cc, fidx, fval, cause, v;
        bit fin, bad;
        ptr = 0; pc = 0; fc = 0; mc = 0; cc = 0; fidx = 0; fval = 0; cause = 0; fin = 0;
        for (int k = 0; k <= len; k++) begin
            if (k > 0 && !fin) begin
                cc++;
                bad = 0;
                if (ptr < NT) begin
                    if (tr_inst[k-1] == m_inst[ptr]) begin
                        v = (m_chan[ptr] == 1) ? tr_l1[k-1] : tr_l0[k-1];
                        if (v == m_ans[ptr]) pc++;
                        else begin
                            if (fc == 0) begin fidx = ptr; fval = v; end
                            fc++;
                            bad = 1;
                        end
                        ptr++;
                    end else if (tr_inst[k-1] > m_inst[ptr]) begin
                        mc++;
                        ptr++;
                    end
                end
                if (bad) begin cause = 2; fin = 1; end
                else if (tr_halt[k-1]) begin cause = 1; fin = 1; end
                else if (cc == MAXC - 1) begin cause = 3; fin = 1; end
            end
            e_busy[k] = fin ? 0 : 1;
            e_done[k] = fin ? 1 : 0;
            e_pc[k] = pc; e_fc[k] = fc; e_mc[k] = mc; e_cc[k] = cc;
            e_fidx[k] = fidx; e_fval[k] = fval; e_cause[k] = cause;
        end
    endtask

    task automatic checkOutput(input int k);
        checkVal($sformatf("busy@%0d", k), 32'(busy), 32'(e_busy[k]));
        checkVal($sformatf("done@%0d", k), 32'(done), 32'(e_done[k]));
        checkVal($sformatf("all_pass@%0d", k), 32'(all_pass),
                 32'((e_done[k] == 1 && e_pc[k] == NT) ? 1 : 0));
        checkVal($sformatf("pass_count@%0d", k), 32'(pass_count), 32'(e_pc[k]));
        checkVal($sformatf("fail_count@%0d", k), 32'(fail_count), 32'(e_fc[k]));
        checkVal($sformatf("miss_count@%0d", k), 32'(miss_count), 32'(e_mc[k]));
        checkVal($sformatf("cycle_count@%0d", k), 32'(cycle_count), 32'(e_cc[k]));
        checkVal($sformatf("fail_idx@%0d", k), 32'(fail_idx), 32'(e_fidx[k]));
        checkVal($sformatf("fail_value@%0d", k), 32'(fail_value), 32'(e_fval[k]));
        checkVal($sformatf("finish_cause@%0d", k), 32'(finish_cause), 32'(e_cause[k]));
    endtask

    task automatic checkCleared();
        checkVal("busy", 32'(busy), 0);
        checkVal("done", 32'(done), 0);
        checkVal("all_pass", 32'(all_pass), 0);
        checkVal("pass_count", 32'(pass_count), 0);
        checkVal("fail_count", 32'(fail_count), 0);
        checkVal("miss_count", 32'(miss_count), 0);
        checkVal("cycle_count", 32'(cycle_count), 0);
        checkVal("fail_idx", 32'(fail_idx), 0);
        checkVal("fail_value", 32'(fail_value), 0);
        checkVal("finish_cause", 32'(finish_cause), 0);
    endtask

    task automatic loadTable();
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            tbl_we = 1'b1; tbl_addr = 2'(i);
            tbl_inst = 16'(m_inst[i]); tbl_ans = 16'(m_ans[i]); tbl_chan = 1'(m_chan[i]);
        end
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic setTable(input int i0, input int a0, input int c0,
                            input int i1, input int a1, input int c1,
                            input int i2, input int a2, input int c2);
        m_inst[0] = i0; m_ans[0] = a0; m_chan[0] = c0;
        m_inst[1] = i1; m_ans[1] = a1; m_chan[1] = c1;
        m_inst[2] = i2; m_ans[2] = a2; m_chan[2] = c2;
    endtask

    // Counting trace 0,1,2,... capped at last_inst, with optional halt cycle.
    task automatic countTrace(input int last_inst, input int halt_at);
        for (int k = 0; k < TLEN; k++) begin
            tr_inst[k] = (k < last_inst) ? k : last_inst;
            tr_l0[k] = 0; tr_l1[k] = 0;
            tr_halt[k] = (k == halt_at);
        end
    endtask

    // Start a run, then drive the trace one cycle at a time and compare after each edge.
    // While the model says RUN, junk table writes are driven; they must be ignored.
    task automatic applyStimulus(input int len);
        buildModel(len);
        @(negedge clk);
        start = 1'b1; tbl_we = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput(0);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            num_inst = 16'(tr_inst[k-1]);
            output_port = {16'(tr_l1[k-1]), 16'(tr_l0[k-1])};
            is_halted = tr_halt[k-1];
            tbl_we = (e_done[k-1] == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            tbl_addr = 2'($urandom_range(0, NT - 1));
            tbl_inst = 16'($urandom); tbl_ans = 16'($urandom); tbl_chan = 1'($urandom);
            @(posedge clk); #1;
            checkOutput(k);
        end
        @(negedge clk);
        tbl_we = 1'b0; is_halted = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tbl_we = 1'b0; tbl_addr = '0;
        tbl_inst = '0; tbl_ans = '0; tbl_chan = '0;
        num_inst = '0; output_port = '0; is_halted = 1'b0;
        step_name = "reset";
        repeat (2) @(posedge clk);
        #1;
        checkCleared();
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] test 1: all checkpoints pass, halt after last");
        step_name = "t1";
        setTable(3, 0, 0, 5, 0, 0, 11, 1, 0);
        loadTable();
        countTrace(12, 12);
        tr_l0[11] = 1;
        applyStimulus(16);

        $display("[TB] test 2: wrong value at last checkpoint");
        step_name = "t2";
        countTrace(12, 12);
        tr_l0[11] = 2;
        applyStimulus(15);

        $display("[TB] test 3: num_inst jumps past all checkpoints");
        step_name = "t3";
        countTrace(12, 99);
        tr_inst[3] = 12; tr_inst[4] = 12; tr_inst[5] = 12;
        tr_inst[6] = 13; tr_halt[6] = 1'b1;
        applyStimulus(10);

        $display("[TB] test 4: watchdog timeout");
        step_name = "t4";
        countTrace(0, 99);
        applyStimulus(24);

        $display("[TB] test 5: lane select, fail then pass");
        step_name = "t5a";
        setTable(3, 0, 0, 5, 0, 0, 7, 16'hFFFE, 1);
        loadTable();
        countTrace(8, 8);
        tr_l0[7] = 16'hFFFE; tr_l1[7] = 16'h0001;
        applyStimulus(12);
        step_name = "t5b";
        tr_l1[7] = 16'hFFFE;
        applyStimulus(12);

        $display("[TB] test 5: reset during a run");
        step_name = "t5r";
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            num_inst = 16'(k);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checkCleared();
        @(negedge clk);
        reset = 1'b0;
        step_name = "t5c";
        applyStimulus(12);

        $display("[TB] test 6: halt in same cycle as final match");
        step_name = "t6";
        setTable(3, 0, 0, 5, 0, 0, 11, 1, 0);
        loadTable();
        countTrace(11, 11);
        tr_l0[11] = 1;
        applyStimulus(14);

        $display("[TB] random runs");
        for (int r = 0; r < 12; r++) begin
            step_name = $sformatf("rnd%0d", r);
            m_inst[0] = $urandom_range(1, 4);
            for (int j = 1; j < NT; j++) m_inst[j] = m_inst[j-1] + $urandom_range(1, 4);
            for (int j = 0; j < NT; j++) begin
                m_ans[j] = $urandom_range(0, 65535);
                m_chan[j] = $urandom_range(0, 1);
            end
            loadTable();
            tr_inst[0] = 0;
            for (int k = 1; k < TLEN; k++) tr_inst[k] = tr_inst[k-1] + $urandom_range(0, 3);
            for (int k = 0; k < TLEN; k++) begin
                tr_l0[k] = $urandom_range(0, 65535);
                tr_l1[k] = $urandom_range(0, 65535);
                for (int j = 0; j < NT; j++) begin
                    if (tr_inst[k] == m_inst[j] && $urandom_range(0, 3) != 0) begin
                        if (m_chan[j] == 1) tr_l1[k] = m_ans[j];
                        else tr_l0[k] = m_ans[j];
                    end
                end
                tr_halt[k] = (tr_inst[k] > m_inst[NT-1]) && ($urandom_range(0, 2) == 0);
            end
            applyStimulus(24);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
